calc_key_entry: RTL and testbench

//  Consumer of the 5-bit calculator key code driven by the mouse hit-test logic
//  (code = row*6+col, 0..17; 18 = no key). Debounces the level code into single

---
 rtl/calc_key_entry.sv | 280 ++++++++++++++++++++++++++++
 tb/tb_calc_key_entry.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/calc_key_entry.sv
// Calculator key entry: debounces the hit-test key code into single press events
// and assembles an "A op B" request for the calculator core over valid/ready.
module calc_key_entry #(
    parameter int STABLE_CYCLES = 4,
    parameter int MAX_DIGITS    = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [4:0]              code,
    input  logic                    req_ready,
    output logic                    req_valid,
    output logic [4*MAX_DIGITS-1:0] operand_a,
    output logic [4*MAX_DIGITS-1:0] operand_b,
    output logic [1:0]              op_code,
    output logic                    key_event,
    output logic [4:0]              key_value,
    output logic [1:0]              entry_phase
);

    localparam int OW = 4 * MAX_DIGITS;
    localparam int CW = $clog2(STABLE_CYCLES + 1);
    localparam int DW = $clog2(MAX_DIGITS + 1);

    typedef enum logic {
        DB_ARMED    = 1'b0,
        DB_WAIT_REL = 1'b1
    } db_state_t;

    typedef enum logic [1:0] {
        PH_ENTER_A = 2'b00,
        PH_ENTER_B = 2'b01,
        PH_ISSUE   = 2'b10,
        PH_DONE    = 2'b11
    } phase_t;

    typedef enum logic [2:0] {
        K_NONE  = 3'd0,
        K_DIGIT = 3'd1,
        K_OP    = 3'd2,
        K_EQ    = 3'd3,
        K_CLR   = 3'd4,
        K_BS    = 3'd5
    } key_kind_t;

    function automatic logic [OW-1:0] bcd_append(input logic [OW-1:0] v, input logic [3:0] d);
        return {v[OW-5:0], d};
    endfunction

    function automatic logic [OW-1:0] bcd_drop(input logic [OW-1:0] v);
        return {4'b0000, v[OW-1:4]};
    endfunction

    db_state_t       db_state_r;
    logic [CW-1:0]   match_cnt_r;
    logic [4:0]      last_code_r;
    logic            key_event_r;
    logic [4:0]      key_value_r;

    phase_t          phase_r;
    logic [OW-1:0]   a_r;
    logic [OW-1:0]   b_r;
    logic [DW-1:0]   cnt_a_r;
    logic [DW-1:0]   cnt_b_r;
    logic [1:0]      op_r;
    logic            req_valid_r;

    logic            idle_s;
    logic [CW-1:0]   run_len_s;
    logic [CW-1:0]   idle_len_s;
    key_kind_t       kind_s;
    logic [3:0]      digit_s;
    logic [1:0]      op_sel_s;

    // Sample classification and run-length arithmetic for the debouncer
    always_comb begin
        idle_s     = (code >= 5'd18);
        idle_len_s = match_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        if ((match_cnt_r != {CW{1'b0}}) && (code == last_code_r)) begin
            run_len_s = match_cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end else begin
            run_len_s = {{(CW-1){1'b0}}, 1'b1};
        end
    end

    // Debouncer: one event per stable press, re-armed only after a stable release
    always_ff @(posedge clk) begin
        if (reset) begin
            db_state_r  <= DB_ARMED;
            match_cnt_r <= {CW{1'b0}};
            last_code_r <= 5'd0;
            key_event_r <= 1'b0;
            key_value_r <= 5'd0;
        end else begin
            key_event_r <= 1'b0;
            case (db_state_r)
                DB_ARMED: begin
                    if (idle_s) begin
                        match_cnt_r <= {CW{1'b0}};
                    end else if (run_len_s == CW'(STABLE_CYCLES)) begin
                        key_event_r <= 1'b1;
                        key_value_r <= code;
                        match_cnt_r <= {CW{1'b0}};
                        db_state_r  <= DB_WAIT_REL;
                    end else begin
                        match_cnt_r <= run_len_s;
                        last_code_r <= code;
                    end
                end
                DB_WAIT_REL: begin
                    if (!idle_s) begin
                        match_cnt_r <= {CW{1'b0}};
                    end else if (idle_len_s == CW'(STABLE_CYCLES)) begin
                        match_cnt_r <= {CW{1'b0}};
                        db_state_r  <= DB_ARMED;
                    end else begin
                        match_cnt_r <= idle_len_s;
                    end
                end
                default: begin
                    match_cnt_r <= {CW{1'b0}};
                    db_state_r  <= DB_ARMED;
                end
            endcase
        end
    end

    // Classify the accepted key; operator codes 10..13 map onto op 00..11
    always_comb begin
        digit_s  = key_value_r[3:0];
        op_sel_s = key_value_r[1:0] + 2'b10;
        if (key_value_r <= 5'd9) begin
            kind_s = K_DIGIT;
        end else if (key_value_r <= 5'd13) begin
            kind_s = K_OP;
        end else if (key_value_r == 5'd14) begin
            kind_s = K_EQ;
        end else if (key_value_r == 5'd15) begin
            kind_s = K_CLR;
        end else if (key_value_r == 5'd16) begin
            kind_s = K_BS;
        end else begin
            kind_s = K_NONE;
        end
    end

    // Operand/operator entry FSM, driven by the registered key event
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_r     <= PH_ENTER_A;
            a_r         <= {OW{1'b0}};
            b_r         <= {OW{1'b0}};
            cnt_a_r     <= {DW{1'b0}};
            cnt_b_r     <= {DW{1'b0}};
            op_r        <= 2'b00;
            req_valid_r <= 1'b0;
        end else begin
            case (phase_r)
                PH_ENTER_A: begin
                    if (key_event_r) begin
                        case (kind_s)
                            K_DIGIT: begin
                                if (cnt_a_r != DW'(MAX_DIGITS)) begin
                                    a_r     <= bcd_append(a_r, digit_s);
                                    cnt_a_r <= cnt_a_r + {{(DW-1){1'b0}}, 1'b1};
                                end
                            end
                            K_BS: begin
                                if (cnt_a_r != {DW{1'b0}}) begin
                                    a_r     <= bcd_drop(a_r);
                                    cnt_a_r <= cnt_a_r - {{(DW-1){1'b0}}, 1'b1};
                                end
                            end
                            K_OP: begin
                                if (cnt_a_r != {DW{1'b0}}) begin
                                    op_r    <= op_sel_s;
                                    phase_r <= PH_ENTER_B;
                                end
                            end
                            K_CLR: begin
                                a_r     <= {OW{1'b0}};
                                b_r     <= {OW{1'b0}};
                                cnt_a_r <= {DW{1'b0}};
                                cnt_b_r <= {DW{1'b0}};
                                op_r    <= 2'b00;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                PH_ENTER_B: begin
                    if (key_event_r) begin
                        case (kind_s)
                            K_DIGIT: begin
                                if (cnt_b_r != DW'(MAX_DIGITS)) begin
                                    b_r     <= bcd_append(b_r, digit_s);
                                    cnt_b_r <= cnt_b_r + {{(DW-1){1'b0}}, 1'b1};
                                end
                            end
                            K_BS: begin
                                // Backspacing past an empty B retracts the operator
                                if (cnt_b_r != {DW{1'b0}}) begin
                                    b_r     <= bcd_drop(b_r);
                                    cnt_b_r <= cnt_b_r - {{(DW-1){1'b0}}, 1'b1};
                                end else begin
                                    op_r    <= 2'b00;
                                    phase_r <= PH_ENTER_A;
                                end
                            end
                            K_OP: begin
                                if (cnt_b_r == {DW{1'b0}}) begin
                                    op_r <= op_sel_s;
                                end
                            end
                            K_EQ: begin
                                if (cnt_b_r != {DW{1'b0}}) begin
                                    req_valid_r <= 1'b1;
                                    phase_r     <= PH_ISSUE;
                                end
                            end
                            K_CLR: begin
                                a_r     <= {OW{1'b0}};
                                b_r     <= {OW{1'b0}};
                                cnt_a_r <= {DW{1'b0}};
                                cnt_b_r <= {DW{1'b0}};
                                op_r    <= 2'b00;
                                phase_r <= PH_ENTER_A;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                PH_ISSUE: begin
                    if (req_valid_r && req_ready) begin
                        req_valid_r <= 1'b0;
                        phase_r     <= PH_DONE;
                    end
                end
                PH_DONE: begin
                    if (key_event_r) begin
                        case (kind_s)
                            K_DIGIT: begin
                                a_r     <= {{(OW-4){1'b0}}, digit_s};
                                cnt_a_r <= {{(DW-1){1'b0}}, 1'b1};
                                b_r     <= {OW{1'b0}};
                                cnt_b_r <= {DW{1'b0}};
                                op_r    <= 2'b00;
                                phase_r <= PH_ENTER_A;
                            end
                            K_CLR: begin
                                a_r     <= {OW{1'b0}};
                                b_r     <= {OW{1'b0}};
                                cnt_a_r <= {DW{1'b0}};
                                cnt_b_r <= {DW{1'b0}};
                                op_r    <= 2'b00;
                                phase_r <= PH_ENTER_A;
                            end
                            default: begin
                            end
                        endcase
                    end
                end
                default: begin
                    phase_r     <= PH_ENTER_A;
                    req_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign req_valid   = req_valid_r;
    assign operand_a   = a_r;
    assign operand_b   = b_r;
    assign op_code     = op_r;
    assign key_event   = key_event_r;
    assign key_value   = key_value_r;
    assign entry_phase = phase_r;

endmodule

// File: tb/tb_calc_key_entry.sv
// Directed self-checking bench for calc_key_entry (STABLE_CYCLES=4, MAX_DIGITS=4).
module tb_calc_key_entry;

    logic        clk;
    logic        reset;
    logic [4:0]  code;
    logic        req_ready;
    logic        req_valid;
    logic [15:0] operand_a;
    logic [15:0] operand_b;
    logic [1:0]  op_code;
    logic        key_event;
    logic [4:0]  key_value;
    logic [1:0]  entry_phase;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int ev_cnt    = 0;
    int ev_base;

    calc_key_entry #(.STABLE_CYCLES(4), .MAX_DIGITS(4)) dut (
        .clk(clk), .reset(reset), .code(code), .req_ready(req_ready),
        .req_valid(req_valid), .operand_a(operand_a), .operand_b(operand_b),
        .op_code(op_code), .key_event(key_event), .key_value(key_value),
        .entry_phase(entry_phase)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_event) ev_cnt = ev_cnt + 1;
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_key(input logic [4:0] k);
        code = k;
        cycles(5);
        code = 5'd18;
        cycles(5);
    endtask

    task automatic handshake();
        req_ready = 1'b1;
        cycles(1);
        req_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; code = 5'd18; req_ready = 1'b0;
        cycles(3);
        total_cnt++;
        if ({req_valid, operand_a, operand_b, op_code, key_event, key_value, entry_phase} !== 42'd0)
            $display("FAIL reset_outputs got a=%h b=%h op=%b v=%b ev=%b kv=%0d ph=%b want all 0",
                     operand_a, operand_b, op_code, req_valid, key_event, key_value, entry_phase);
        else pass_cnt++;
        reset = 1'b0;
        ev_base = ev_cnt;
        cycles(20);
        total_cnt++;
        if (ev_cnt - ev_base !== 0) $display("FAIL reset_idle_events got %0d want 0", ev_cnt - ev_base);
        else pass_cnt++;
    endtask

    task automatic test_debounce();
        ev_base = ev_cnt;
        code = 5'd1;
        cycles(3);
        code = 5'd18;
        cycles(6);
        total_cnt++;
        if (ev_cnt - ev_base !== 0) $display("FAIL short_press_events got %0d want 0", ev_cnt - ev_base);
        else pass_cnt++;
        code = 5'd1;
        cycles(100);
        code = 5'd18;
        cycles(6);
        total_cnt++;
        if (ev_cnt - ev_base !== 1) $display("FAIL held_press_events got %0d want 1", ev_cnt - ev_base);
        else pass_cnt++;
        total_cnt++;
        if (key_value !== 5'd1) $display("FAIL held_key_value got %0d want 1", key_value);
        else pass_cnt++;
        total_cnt++;
        if (operand_a !== 16'h0001) $display("FAIL held_operand_a got %h want 0001", operand_a);
        else pass_cnt++;
    endtask

    task automatic test_issue();
        press_key(5'd15);
        press_key(5'd1); press_key(5'd2); press_key(5'd10); press_key(5'd3); press_key(5'd14);
        total_cnt++;
        if (req_valid !== 1'b1 || entry_phase !== 2'b10)
            $display("FAIL issue_valid got v=%b ph=%b want v=1 ph=10", req_valid, entry_phase);
        else pass_cnt++;
        total_cnt++;
        if (operand_a !== 16'h0012 || operand_b !== 16'h0003 || op_code !== 2'b00)
            $display("FAIL issue_request got a=%h b=%h op=%b want a=0012 b=0003 op=00",
                     operand_a, operand_b, op_code);
        else pass_cnt++;
        for (int i = 0; i < 6; i++) begin
            cycles(1);
            total_cnt++;
            if (req_valid !== 1'b1 || operand_a !== 16'h0012 || operand_b !== 16'h0003 || op_code !== 2'b00)
                $display("FAIL issue_stable cycle %0d got v=%b a=%h b=%h op=%b want v=1 a=0012 b=0003 op=00",
                         i, req_valid, operand_a, operand_b, op_code);
            else pass_cnt++;
        end
        handshake();
        total_cnt++;
        if (req_valid !== 1'b0 || entry_phase !== 2'b11)
            $display("FAIL handshake_done got v=%b ph=%b want v=0 ph=11", req_valid, entry_phase);
        else pass_cnt++;
        total_cnt++;
        if (operand_a !== 16'h0012 || operand_b !== 16'h0003)
            $display("FAIL done_hold got a=%h b=%h want a=0012 b=0003", operand_a, operand_b);
        else pass_cnt++;
    endtask

    task automatic test_digits_backspace();
        press_key(5'd15);
        press_key(5'd1); press_key(5'd2); press_key(5'd3); press_key(5'd4); press_key(5'd5);
        total_cnt++;
        if (operand_a !== 16'h1234) $display("FAIL digit_limit got %h want 1234", operand_a);
        else pass_cnt++;
        press_key(5'd16);
        total_cnt++;
        if (operand_a !== 16'h0123) $display("FAIL backspace got %h want 0123", operand_a);
        else pass_cnt++;
        press_key(5'd10); press_key(5'd4); press_key(5'd14);
        handshake();
        total_cnt++;
        if (entry_phase !== 2'b11) $display("FAIL reach_done got ph=%b want 11", entry_phase);
        else pass_cnt++;
        press_key(5'd7);
        total_cnt++;
        if (operand_a !== 16'h0007 || operand_b !== 16'h0000 || op_code !== 2'b00 || entry_phase !== 2'b00)
            $display("FAIL done_new_digit got a=%h b=%h op=%b ph=%b want a=0007 b=0000 op=00 ph=00",
                     operand_a, operand_b, op_code, entry_phase);
        else pass_cnt++;
    endtask

    task automatic test_ignored_keys();
        press_key(5'd15);
        press_key(5'd10);
        total_cnt++;
        if (entry_phase !== 2'b00 || op_code !== 2'b00)
            $display("FAIL op_empty_a got ph=%b op=%b want ph=00 op=00", entry_phase, op_code);
        else pass_cnt++;
        press_key(5'd9); press_key(5'd11); press_key(5'd14);
        total_cnt++;
        if (entry_phase !== 2'b01 || op_code !== 2'b01 || req_valid !== 1'b0)
            $display("FAIL eq_empty_b got ph=%b op=%b v=%b want ph=01 op=01 v=0", entry_phase, op_code, req_valid);
        else pass_cnt++;
        press_key(5'd12);
        total_cnt++;
        if (op_code !== 2'b10) $display("FAIL op_replace got %b want 10", op_code);
        else pass_cnt++;
        press_key(5'd15);
        total_cnt++;
        if (operand_a !== 16'h0000 || operand_b !== 16'h0000 || op_code !== 2'b00 || entry_phase !== 2'b00)
            $display("FAIL clear_b got a=%h b=%h op=%b ph=%b want all 0", operand_a, operand_b, op_code, entry_phase);
        else pass_cnt++;
        press_key(5'd9); press_key(5'd13); press_key(5'd16);
        total_cnt++;
        if (entry_phase !== 2'b00 || op_code !== 2'b00 || operand_a !== 16'h0009)
            $display("FAIL bs_empty_b got ph=%b op=%b a=%h want ph=00 op=00 a=0009", entry_phase, op_code, operand_a);
        else pass_cnt++;
        ev_base = ev_cnt;
        press_key(5'd17);
        total_cnt++;
        if (ev_cnt - ev_base !== 1 || key_value !== 5'd17 || operand_a !== 16'h0009 || entry_phase !== 2'b00)
            $display("FAIL key17 got ev=%0d kv=%0d a=%h ph=%b want ev=1 kv=17 a=0009 ph=00",
                     ev_cnt - ev_base, key_value, operand_a, entry_phase);
        else pass_cnt++;
    endtask

    task automatic test_reset_mid_issue();
        press_key(5'd15);
        press_key(5'd5); press_key(5'd12); press_key(5'd6); press_key(5'd14);
        ev_base = ev_cnt;
        press_key(5'd15);
        total_cnt++;
        if (ev_cnt - ev_base !== 1 || entry_phase !== 2'b10 || req_valid !== 1'b1 ||
            operand_a !== 16'h0005 || operand_b !== 16'h0006 || op_code !== 2'b10)
            $display("FAIL issue_ignores_clear got ev=%0d ph=%b v=%b a=%h b=%h op=%b want ev=1 ph=10 v=1 a=0005 b=0006 op=10",
                     ev_cnt - ev_base, entry_phase, req_valid, operand_a, operand_b, op_code);
        else pass_cnt++;
        reset = 1'b1;
        cycles(1);
        reset = 1'b0;
        total_cnt++;
        if (req_valid !== 1'b0 || operand_a !== 16'h0000 || operand_b !== 16'h0000 ||
            op_code !== 2'b00 || entry_phase !== 2'b00)
            $display("FAIL reset_mid_issue got v=%b a=%h b=%h op=%b ph=%b want all 0",
                     req_valid, operand_a, operand_b, op_code, entry_phase);
        else pass_cnt++;
    endtask

    initial begin
        reset = 1'b1; code = 5'd18; req_ready = 1'b0;
        test_reset();
        test_debounce();
        test_issue();
        test_digits_backspace();
        test_ignored_keys();
        test_reset_mid_issue();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
